// File: rtl/ns_route_tester.sv
// Self-checking traffic generator/checker for a 1-to-N message router.
// One source channel sweeps MIN_ADDR..MAX_ADDR; NUM_SNK sink channels check what comes back.
module ns_route_tester #(
  parameter int ASZ      = 6,
  parameter int DSZ      = 4,
  parameter int NUM_SNK  = 2,
  parameter int MIN_ADDR = 0,
  parameter int MAX_ADDR = 55,
  parameter int OPER     = 0,
  parameter int REF_VAL  = 23,
  parameter int SRC_DIV  = 8,
  parameter int SNK_DIV  = 64,
  parameter int TIMEOUT  = 4096
) (
  input  logic                   i_clk,
  input  logic                   reset,
  output logic                   o0_req,
  output logic [ASZ-1:0]         o0_addr,
  output logic [DSZ-1:0]         o0_data,
  input  logic                   o0_ack,
  input  logic [NUM_SNK-1:0]     i_req,
  input  logic [NUM_SNK*ASZ-1:0] i_addr,
  input  logic [NUM_SNK*DSZ-1:0] i_data,
  output logic [NUM_SNK-1:0]     i_ack,
  output logic                   o_done,
  output logic                   o_err,
  output logic                   o_timeout,
  output logic [ASZ:0]           o_sent_cnt,
  output logic [ASZ:0]           o_rcvd_cnt,
  output logic [7:0]             o_err_cnt,
  output logic [3:0]             o_disp0,
  output logic [3:0]             o_disp1,
  output logic [3:0]             o_leds
);

  localparam int SPAN   = MAX_ADDR - MIN_ADDR + 1;
  localparam int SRC_W  = $clog2(SRC_DIV + 1);
  localparam int SNK_W  = $clog2(SNK_DIV + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [ASZ-1:0]    MIN_A     = ASZ'(MIN_ADDR);
  localparam logic [ASZ-1:0]    MAX_A     = ASZ'(MAX_ADDR);
  localparam logic [ASZ-1:0]    REF_A     = ASZ'(REF_VAL);
  localparam logic [ASZ-1:0]    SPAN_M1   = ASZ'(MAX_ADDR - MIN_ADDR);
  localparam logic [ASZ:0]      SPAN_C    = (ASZ+1)'(SPAN);
  localparam logic [IDLE_W-1:0] TIMEOUT_C = IDLE_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL, S_DONE} src_st_t;
  typedef enum logic {K_WAIT, K_REL} snk_st_t;
  typedef enum logic [2:0] {E_NONE, E_RANGE, E_DEST, E_PAY, E_DUP} err_t;

  function automatic logic route_hit(input logic [ASZ-1:0] a);
    case (OPER)
      0:       route_hit = (a > REF_A);
      1:       route_hit = (a < REF_A);
      2:       route_hit = (a == REF_A);
      default: route_hit = (a != REF_A);
    endcase
  endfunction

  // First failing check wins; a message is charged at most one error.
  function automatic err_t classify(input logic rng_ok, input logic dst_ok,
                                    input logic pay_ok, input logic dup);
    if (!rng_ok)      return E_RANGE;
    else if (!dst_ok) return E_DEST;
    else if (!pay_ok) return E_PAY;
    else if (dup)     return E_DUP;
    else              return E_NONE;
  endfunction

  function automatic logic [3:0] ones(input logic [NUM_SNK-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_SNK; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [7:0] err_sat_add(input logic [7:0] cnt, input logic [3:0] inc);
    logic [8:0] s;
    s = {1'b0, cnt} + {5'b00000, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [SRC_W-1:0]  src_div_cnt;
  logic [SNK_W-1:0]  snk_div_cnt;
  logic              src_tick, snk_tick;
  src_st_t           src_st;
  logic [ASZ-1:0]    addr_q;
  logic [ASZ:0]      sent_q, rcvd_q;
  snk_st_t           snk_st [NUM_SNK];
  logic [NUM_SNK-1:0] ack_q;
  logic [SPAN-1:0]   seen_q, seen_run;
  logic [NUM_SNK-1:0] acc, bad;
  logic [7:0]        err_q;
  logic [IDLE_W-1:0] idle_q;
  logic              done_q, timeout_q, to_ev;

  assign src_tick = (src_div_cnt == SRC_W'(SRC_DIV - 1));
  assign snk_tick = (snk_div_cnt == SNK_W'(SNK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (reset || src_tick) src_div_cnt <= '0;
    else                   src_div_cnt <= src_div_cnt + SRC_W'(1);
    if (reset || snk_tick) snk_div_cnt <= '0;
    else                   snk_div_cnt <= snk_div_cnt + SNK_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      src_st <= S_IDLE;
      o0_req <= 1'b0;
      addr_q <= MIN_A;
      sent_q <= '0;
    end else begin
      case (src_st)
        S_IDLE: if (src_tick) begin
          o0_req <= 1'b1;
          src_st <= S_REQ;
        end
        S_REQ: if (o0_ack) begin
          o0_req <= 1'b0;
          src_st <= S_REL;
        end
        S_REL: if (!o0_ack) begin
          sent_q <= sent_q + (ASZ+1)'(1);
          if (addr_q == MAX_A) begin
            src_st <= S_DONE;
          end else begin
            addr_q <= addr_q + ASZ'(1);
            src_st <= S_IDLE;
          end
        end
        default: src_st <= S_DONE;
      endcase
    end
  end

  assign o0_addr = addr_q;
  assign o0_data = addr_q[DSZ-1:0];

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_SNK; k++) begin
      if (reset) begin
        snk_st[k] <= K_WAIT;
        ack_q[k]  <= 1'b0;
      end else begin
        case (snk_st[k])
          K_WAIT: if (acc[k]) begin
            ack_q[k]  <= 1'b1;
            snk_st[k] <= K_REL;
          end
          default: if (!i_req[k]) begin
            ack_q[k]  <= 1'b0;
            snk_st[k] <= K_WAIT;
          end
        endcase
      end
    end
  end

  assign i_ack = ack_q;

  // Channels are walked in index order so a lower channel claims a shared address first.
  always_comb begin
    logic [ASZ-1:0]  a, off;
    logic [DSZ-1:0]  d;
    logic            rng_ok, dst_ok;
    logic [SPAN-1:0] onehot;
    a        = '0;
    off      = '0;
    d        = '0;
    rng_ok   = 1'b0;
    dst_ok   = 1'b0;
    onehot   = '0;
    seen_run = seen_q;
    acc      = '0;
    bad      = '0;
    for (int k = 0; k < NUM_SNK; k++) begin
      a      = i_addr[k*ASZ +: ASZ];
      d      = i_data[k*DSZ +: DSZ];
      off    = a - MIN_A;
      rng_ok = (off <= SPAN_M1);
      for (int i = 0; i < SPAN; i++) onehot[i] = rng_ok && (off == ASZ'(i));
      dst_ok = (k == 0) ? route_hit(a) : !route_hit(a);
      acc[k] = snk_tick && i_req[k] && (snk_st[k] == K_WAIT);
      bad[k] = acc[k] && (classify(rng_ok, dst_ok, d == a[DSZ-1:0],
                                   |(seen_run & onehot)) != E_NONE);
      if (acc[k]) seen_run = seen_run | onehot;
    end
  end

  assign to_ev = (idle_q == TIMEOUT_C) && !done_q && !timeout_q;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      seen_q    <= '0;
      rcvd_q    <= '0;
      err_q     <= '0;
      idle_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      seen_q <= seen_run;
      rcvd_q <= rcvd_q + (ASZ+1)'(ones(acc));
      err_q  <= err_sat_add(err_q, ones(bad) + {3'b000, to_ev});
      if (|acc)                  idle_q <= '0;
      else if (idle_q != TIMEOUT_C) idle_q <= idle_q + IDLE_W'(1);
      if (to_ev) timeout_q <= 1'b1;
      if (src_st == S_DONE && rcvd_q == SPAN_C) done_q <= 1'b1;
    end
  end

  assign o_done     = done_q;
  assign o_timeout  = timeout_q;
  assign o_sent_cnt = sent_q;
  assign o_rcvd_cnt = rcvd_q;
  assign o_err_cnt  = err_q;
  assign o_err      = (err_q != 8'd0);
  assign o_disp0    = (err_q > 8'd15) ? 4'hF : err_q[3:0];
  assign o_disp1    = {src_st, done_q, timeout_q};
  assign o_leds     = {(src_st == S_REQ) || (src_st == S_REL), timeout_q, o_err, done_q};

endmodule
